// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-end: synchronises and debounces four buttons, runs the
// IDLE/RUNNING/PAUSED machine, generates clear/advance pulses and captures lap times.
module stopwatch_ctrl #(
    parameter int TICK_DIV   = 100000000,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_reset,
    input  logic       btn_lap,
    input  logic [7:0] minutes,
    input  logic [5:0] seconds,
    output logic       tick,
    output logic       clr,
    output logic [1:0] status,
    output logic [7:0] lap_min,
    output logic [5:0] lap_sec,
    output logic       lap_valid,
    output logic       lap_stb
);

    localparam int            CW        = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
    localparam logic [31:0]   TICK_LAST = 32'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10
    } state_t;

    // Bit order used throughout: 0 start, 1 stop, 2 reset, 3 lap.
    logic [3:0] w_btn_raw;
    logic [3:0] w_ev;
    assign w_btn_raw = {btn_lap, btn_reset, btn_stop, btn_start};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_btn
            logic          r_s1, r_s2, r_d, r_dp, r_p;
            logic [CW-1:0] r_c;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s1 <= 1'b0;
                    r_s2 <= 1'b0;
                    r_d  <= 1'b0;
                    r_dp <= 1'b0;
                    r_p  <= 1'b0;
                    r_c  <= '0;
                end else begin
                    r_s1 <= w_btn_raw[gi];
                    r_s2 <= r_s1;
                    r_dp <= r_d;
                    // Registered press pulse keeps inputs off any combinational output path.
                    r_p  <= r_d & ~r_dp;
                    if (r_s2 == r_d) begin
                        r_c <= '0;
                    end else if (r_c == DEB_LAST) begin
                        r_d <= r_s2;
                        r_c <= '0;
                    end else begin
                        r_c <= r_c + 1'b1;
                    end
                end
            end

            assign w_ev[gi] = r_p;
        end
    endgenerate

    // Only the highest-priority event of a cycle is allowed to act.
    logic w_act_reset, w_act_stop, w_act_start, w_act_lap;
    assign w_act_reset = w_ev[2];
    assign w_act_stop  = w_ev[1] & ~w_ev[2];
    assign w_act_start = w_ev[0] & ~w_ev[1] & ~w_ev[2];
    assign w_act_lap   = w_ev[3] & ~w_ev[0] & ~w_ev[1] & ~w_ev[2];

    state_t      r_state;
    logic [31:0] r_presc;
    logic        r_tick, r_clr, r_lap_valid, r_lap_stb;
    logic [7:0]  r_lap_min;
    logic [5:0]  r_lap_sec;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_presc     <= '0;
            r_tick      <= 1'b0;
            r_clr       <= 1'b0;
            r_lap_valid <= 1'b0;
            r_lap_stb   <= 1'b0;
            r_lap_min   <= '0;
            r_lap_sec   <= '0;
        end else begin
            r_tick    <= 1'b0;
            r_clr     <= 1'b0;
            r_lap_stb <= 1'b0;
            if (w_act_reset) begin
                r_state     <= S_IDLE;
                r_clr       <= 1'b1;
                r_presc     <= '0;
                r_lap_valid <= 1'b0;
                r_lap_min   <= '0;
                r_lap_sec   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_act_start) begin
                            r_state <= S_RUN;
                            r_presc <= '0;
                        end
                    end
                    S_RUN: begin
                        // A stop freezes the prescaler so resume keeps the fractional second.
                        if (w_act_stop) begin
                            r_state <= S_PAUSE;
                        end else begin
                            if (r_presc == TICK_LAST) begin
                                r_presc <= '0;
                                r_tick  <= 1'b1;
                            end else begin
                                r_presc <= r_presc + 32'd1;
                            end
                            if (w_act_lap) begin
                                r_lap_min   <= minutes;
                                r_lap_sec   <= seconds;
                                r_lap_valid <= 1'b1;
                                r_lap_stb   <= 1'b1;
                            end
                        end
                    end
                    S_PAUSE: begin
                        if (w_act_start) begin
                            r_state <= S_RUN;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign tick      = r_tick;
    assign clr       = r_clr;
    assign status    = r_state;
    assign lap_min   = r_lap_min;
    assign lap_sec   = r_lap_sec;
    assign lap_valid = r_lap_valid;
    assign lap_stb   = r_lap_stb;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a small minutes/seconds counter model
// driven by the controller's tick/clr outputs.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_start = 1'b0, btn_stop = 1'b0, btn_reset = 1'b0, btn_lap = 1'b0;
    logic [7:0] minutes;
    logic [5:0] seconds;
    logic       tick, clr, lap_valid, lap_stb;
    logic [1:0] status;
    logic [7:0] lap_min;
    logic [5:0] lap_sec;

    int errors = 0;
    int checks = 0;

    stopwatch_ctrl #(.TICK_DIV(10), .DEB_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .btn_start(btn_start), .btn_stop(btn_stop), .btn_reset(btn_reset), .btn_lap(btn_lap),
        .minutes(minutes), .seconds(seconds),
        .tick(tick), .clr(clr), .status(status),
        .lap_min(lap_min), .lap_sec(lap_sec), .lap_valid(lap_valid), .lap_stb(lap_stb)
    );

    always #5 clk = ~clk;

    // Counter datapath model
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            minutes <= 8'd0;
            seconds <= 6'd0;
        end else if (tick) begin
            if (seconds == 6'd59) begin
                seconds <= 6'd0;
                minutes <= minutes + 8'd1;
            end else begin
                seconds <= seconds + 6'd1;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Mask bits: 0 start, 1 stop, 2 reset, 3 lap. Returns at the cycle the event acts.
    task automatic press(input logic [3:0] m);
        {btn_lap, btn_reset, btn_stop, btn_start} = m;
        step(8);
        {btn_lap, btn_reset, btn_stop, btn_start} = 4'b0;
    endtask

    task automatic wait_tick(output int n);
        n = -1;
        for (int i = 1; i <= 40 && n < 0; i++) begin
            step(1);
            if (tick) n = i;
        end
    endtask

    task automatic test_reset;
        int bad;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        checks++; if (status !== 2'b00) begin errors++; $display("FAIL reset_status got=%b exp=00", status); end
        checks++; if ({tick, clr, lap_valid, lap_stb} !== 4'b0) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {tick, clr, lap_valid, lap_stb}); end
        checks++; if ({lap_min, lap_sec} !== 14'd0) begin errors++; $display("FAIL reset_lap got=%0d:%0d exp=0:0", lap_min, lap_sec); end
        $display("reset: status=%b tick=%b clr=%b lap_valid=%b", status, tick, clr, lap_valid);
        btn_start = 1'b1;
        step(3);
        btn_start = 1'b0;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            step(1);
            if (status !== 2'b00 || tick !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL glitch_ignored got=%0d bad cycles exp=0", bad); end
        $display("glitch: 3-cycle start pulse, status=%b", status);
    endtask

    task automatic test_start_run;
        int n, bad;
        btn_start = 1'b1;
        step(7);
        checks++; if (status !== 2'b00) begin errors++; $display("FAIL start_latency_early got=%b exp=00", status); end
        step(1);
        btn_start = 1'b0;
        checks++; if (status !== 2'b01) begin errors++; $display("FAIL start_latency got=%b exp=01", status); end
        wait_tick(n);
        checks++; if (n != 10) begin errors++; $display("FAIL first_tick got=%0d exp=10", n); end
        bad = 0;
        for (int k = 2; k <= 60; k++) begin
            wait_tick(n);
            if (n != 10) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL tick_period got=%0d bad intervals exp=0", bad); end
        step(1);
        checks++; if (minutes !== 8'd1 || seconds !== 6'd0) begin errors++; $display("FAIL sixty_ticks got=%0d:%0d exp=1:0", minutes, seconds); end
        $display("run: 60 ticks, counter=%0d:%0d", minutes, seconds);
    endtask

    task automatic test_pause_resume;
        int n, cnt;
        wait_tick(n);
        // Stop acts 8 cycles after this tick, freezing the prescaler at 7.
        btn_stop = 1'b1;
        step(7);
        checks++; if (status !== 2'b01) begin errors++; $display("FAIL stop_early got=%b exp=01", status); end
        step(1);
        btn_stop = 1'b0;
        checks++; if (status !== 2'b10 || tick !== 1'b0) begin errors++; $display("FAIL stop_state got=%b/%b exp=10/0", status, tick); end
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (tick) cnt++;
        end
        checks++; if (cnt != 0) begin errors++; $display("FAIL paused_ticks got=%0d exp=0", cnt); end
        press(4'b0001);
        checks++; if (status !== 2'b01) begin errors++; $display("FAIL resume_state got=%b exp=01", status); end
        wait_tick(n);
        checks++; if (n != 3) begin errors++; $display("FAIL resume_tick got=%0d exp=3", n); end
        $display("pause/resume: first tick %0d cycles after resume", n);
    endtask

    task automatic test_lap;
        int n;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        press(4'b0001);
        for (int k = 0; k < 42; k++) wait_tick(n);
        btn_lap = 1'b1;
        step(8);
        btn_lap = 1'b0;
        checks++; if (lap_stb !== 1'b1 || lap_valid !== 1'b1) begin errors++; $display("FAIL lap_pulse got=%b/%b exp=1/1", lap_stb, lap_valid); end
        checks++; if (lap_min !== 8'd0 || lap_sec !== 6'd42) begin errors++; $display("FAIL lap_value got=%0d:%0d exp=0:42", lap_min, lap_sec); end
        step(1);
        checks++; if (lap_stb !== 1'b0 || lap_valid !== 1'b1) begin errors++; $display("FAIL lap_stb_width got=%b/%b exp=0/1", lap_stb, lap_valid); end
        $display("lap: captured %0d:%0d", lap_min, lap_sec);
        wait_tick(n);
        wait_tick(n);
        press(4'b0010);
        checks++; if (status !== 2'b10) begin errors++; $display("FAIL lap_pause_state got=%b exp=10", status); end
        step(10);
        press(4'b1000);
        checks++; if (lap_stb !== 1'b0 || lap_sec !== 6'd42) begin errors++; $display("FAIL lap_paused got=%b/%0d exp=0/42", lap_stb, lap_sec); end
        $display("lap while paused: lap_sec=%0d counter sec=%0d", lap_sec, seconds);
    endtask

    task automatic test_simultaneous;
        step(10);
        press(4'b0001);
        checks++; if (status !== 2'b01) begin errors++; $display("FAIL simul_resume got=%b exp=01", status); end
        step(10);
        press(4'b1011);
        checks++; if (status !== 2'b10 || lap_stb !== 1'b0 || lap_sec !== 6'd42) begin errors++; $display("FAIL simul_stop got=%b/%b/%0d exp=10/0/42", status, lap_stb, lap_sec); end
        step(10);
        press(4'b0101);
        checks++; if (status !== 2'b00 || clr !== 1'b1 || lap_valid !== 1'b0 || lap_sec !== 6'd0) begin errors++; $display("FAIL simul_reset got=%b/%b/%b/%0d exp=00/1/0/0", status, clr, lap_valid, lap_sec); end
        step(1);
        checks++; if (clr !== 1'b0 || status !== 2'b00) begin errors++; $display("FAIL clr_width got=%b/%b exp=0/00", clr, status); end
        $display("simultaneous: status=%b lap_valid=%b", status, lap_valid);
    endtask

    task automatic test_rst_midrun;
        int n;
        step(10);
        press(4'b0001);
        press(4'b1000);
        checks++; if (lap_valid !== 1'b1) begin errors++; $display("FAIL midrun_lap got=%b exp=1", lap_valid); end
        // Tick at start+10, so prescaler holds 6 eight cycles after the lap.
        step(8);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        checks++; if (status !== 2'b00 || {tick, clr, lap_valid, lap_stb} !== 4'b0 || {lap_min, lap_sec} !== 14'd0) begin
            errors++; $display("FAIL midrun_rst got=%b/%b%b%b%b exp=00/0000", status, tick, clr, lap_valid, lap_stb);
        end
        press(4'b0001);
        checks++; if (status !== 2'b01) begin errors++; $display("FAIL restart_state got=%b exp=01", status); end
        wait_tick(n);
        checks++; if (n != 10) begin errors++; $display("FAIL restart_tick got=%0d exp=10", n); end
        $display("rst mid-run: restart first tick after %0d cycles", n);
    endtask

    initial begin
        step(1);
        test_reset();
        test_start_run();
        test_pause_resume();
        test_lap();
        test_simultaneous();
        test_rst_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
